// File: rtl/load_store_unit_if.sv
// Data-memory request/ready bus between the load/store unit and a wait-stated memory.
// No storage, so the bus adds no latency.
// Backpressure: the memory holds mem_ready low to stretch a request, and the master holds its fields stable meanwhile.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access stage: aligns stores onto byte lanes, extends loads, and flags bad or timed-out accesses.
// Latency: 3 cycles per access when memory is ready, plus 1 per wait cycle; 2 cycles for a rejected access.
// Backpressure: Stall holds the core until DONE; requests stay stable until mem_ready and are abandoned after TIMEOUT waits.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [2:0]               DataSrc,
    input  logic [2:0]               StoreFunct3,
    input  logic [31:0]              ALUResult,
    input  logic [31:0]              WriteData,
    output logic                     Stall,
    output logic [31:0]              ReadData,
    output logic                     AccessErr,
    load_store_unit_if.master        mem
);

    // Counter must hold TIMEOUT, but never narrower than a byte.
    localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             err_q,       err_d;
    logic             store_q,     store_d;
    logic [2:0]       ld_type_q,   ld_type_d;
    logic [1:0]       lane_q,      lane_d;
    logic [31:0]      rdata_q,     rdata_d;
    logic             mem_req_q,   mem_req_d;
    logic             mem_we_q,    mem_we_d;
    logic [31:0]      mem_addr_q,  mem_addr_d;
    logic [3:0]       mem_be_q,    mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic             req_any;
    logic [1:0]       req_size;
    logic             req_illegal;
    logic             req_misaligned;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_ext;
    logic [CNT_W-1:0] cnt_inc;

    // Decode the incoming instruction: size, legality, alignment and lane placement.
    always_comb begin
        req_any        = MemRead | MemWrite;
        req_size       = MemWrite ? StoreFunct3[1:0] : DataSrc[1:0];
        req_illegal    = MemWrite ? (StoreFunct3 >= 3'b011)
                                  : ((DataSrc == 3'b011) || (DataSrc[2:1] == 2'b11));
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        req_wdata      = WriteData;
        case (req_size)
            2'b00: begin
                req_be    = 4'b0001 << ALUResult[1:0];
                req_wdata = {4{WriteData[7:0]}};
            end
            2'b01: begin
                req_misaligned = ALUResult[0];
                req_be         = 4'b0011 << ALUResult[1:0];
                req_wdata      = {2{WriteData[15:0]}};
            end
            2'b10: begin
                req_misaligned = |ALUResult[1:0];
            end
            default: begin
                // Size 11 is always flagged illegal above.
                req_misaligned = 1'b0;
            end
        endcase
    end

    // Pick the addressed byte/halfword out of the returned word and extend it.
    always_comb begin
        ld_byte = mem.mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = mem.mem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (ld_type_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    // Next-state and next-output logic for the IDLE/REQ/DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        store_d     = store_q;
        ld_type_d   = ld_type_q;
        lane_d      = lane_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        cnt_inc     = cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    // A simultaneous load and store is treated as a store.
                    store_d   = MemWrite;
                    ld_type_d = DataSrc;
                    lane_d    = ALUResult[1:0];
                    rdata_d   = '0;
                    cnt_d     = '0;
                    if (req_illegal || req_misaligned) begin
                        // Rejected before touching memory.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d       = 1'b0;
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWrite;
                        mem_addr_d  = {ALUResult[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
                    if (!store_q) begin
                        rdata_d = ld_ext;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if ((TIMEOUT != 0) && (cnt_inc == TIMEOUT_C)) begin
                        // Give up: drop the request and retire with an error.
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Instruction retires here; the next one is seen in IDLE.
                state_d = S_IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and registered bus outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            store_q     <= 1'b0;
            ld_type_q   <= 3'b000;
            lane_q      <= 2'b00;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            store_q     <= store_d;
            ld_type_q   <= ld_type_d;
            lane_q      <= lane_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Core-facing outputs; Stall covers the decode cycle itself, so it stays combinational.
    always_comb begin
        Stall         = !reset && (((state_q == S_IDLE) && req_any) || (state_q == S_REQ));
        ReadData      = ((state_q == S_DONE) && !err_q) ? rdata_q : 32'h0;
        AccessErr     = (state_q == S_DONE) && err_q;
        mem.mem_req   = mem_req_q;
        mem.mem_we    = mem_we_q;
        mem.mem_addr  = mem_addr_q;
        mem.mem_be    = mem_be_q;
        mem.mem_wdata = mem_wdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: drives load/store instructions against a scripted wait-state memory.
// Latency: results are scored in the first cycle where Stall drops, which is the DONE cycle.
// Backpressure: mem_ready is held low for a per-access number of REQ cycles to exercise waits and the timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  DataSrc;
    logic [2:0]  StoreFunct3;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        Stall;
    logic [31:0] ReadData;
    logic        AccessErr;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .DataSrc     (DataSrc),
        .StoreFunct3 (StoreFunct3),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData),
        .Stall       (Stall),
        .ReadData    (ReadData),
        .AccessErr   (AccessErr),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one instruction, watch the memory bus every stalled cycle, and score the DONE cycle.
    task automatic do_op(input string name, input logic rd, input logic wr,
                         input logic [2:0] ds, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                         input int delay,
                         input logic [31:0] e_addr, input logic [3:0] e_be, input logic chk_be,
                         input logic [31:0] e_wdata, input logic e_we,
                         input logic [31:0] e_data, input logic e_err,
                         input int e_stalls, input int e_reqs);
        exp_t e;
        exp_t g;
        int   stalls = 0;
        int   reqs   = 0;
        bit   done   = 0;
        e.data   = e_data;
        e.err    = e_err;
        e.stalls = e_stalls;
        e.reqs   = e_reqs;
        sb_q.push_back(e);

        @(posedge clk); #1;
        MemRead       = rd;
        MemWrite      = wr;
        DataSrc       = ds;
        StoreFunct3   = f3;
        ALUResult     = addr;
        WriteData     = wd;
        bus.mem_rdata = rdat;
        bus.mem_ready = (delay == 0);

        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (Stall) begin
                stalls++;
                if (bus.mem_req) begin
                    reqs++;
                    check_eq({name, ".addr"}, bus.mem_addr, e_addr);
                    check_eq({name, ".we"}, {31'h0, bus.mem_we}, {31'h0, e_we});
                    if (chk_be) check_eq({name, ".be"}, {28'h0, bus.mem_be}, {28'h0, e_be});
                    if (e_we) check_eq({name, ".wdata"}, bus.mem_wdata, e_wdata);
                    bus.mem_ready = (reqs > delay);
                end
            end else begin
                done = 1;
                g = sb_q.pop_front();
                check_eq({name, ".rdata"}, ReadData, g.data);
                check_eq({name, ".err"}, {31'h0, AccessErr}, {31'h0, g.err});
                check_eq({name, ".stalls"}, 32'(stalls), 32'(g.stalls));
                check_eq({name, ".reqs"}, 32'(reqs), 32'(g.reqs));
                MemRead       = 1'b0;
                MemWrite      = 1'b0;
                bus.mem_ready = 1'b0;
            end
        end
        check_eq({name, ".completed"}, {31'h0, done}, 32'h1);

        @(negedge clk);
        check_eq({name, ".after_stall"}, {31'h0, Stall}, 32'h0);
        check_eq({name, ".after_err"}, {31'h0, AccessErr}, 32'h0);
        check_eq({name, ".after_req"}, {31'h0, bus.mem_req}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        MemRead       = 1'b1;
        MemWrite      = 1'b0;
        DataSrc       = 3'b010;
        StoreFunct3   = 3'b000;
        ALUResult     = 32'h0;
        WriteData     = 32'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst.stall", {31'h0, Stall}, 32'h0);
        check_eq("rst.req", {31'h0, bus.mem_req}, 32'h0);
        check_eq("rst.we", {31'h0, bus.mem_we}, 32'h0);
        check_eq("rst.be", {28'h0, bus.mem_be}, 32'h0);
        check_eq("rst.addr", bus.mem_addr, 32'h0);
        check_eq("rst.wdata", bus.mem_wdata, 32'h0);
        check_eq("rst.rdata", ReadData, 32'h0);
        check_eq("rst.err", {31'h0, AccessErr}, 32'h0);

        @(posedge clk); #1;
        reset         = 1'b0;
        MemRead       = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("nomem.stall", {31'h0, Stall}, 32'h0);
            check_eq("nomem.req", {31'h0, bus.mem_req}, 32'h0);
        end
        bus.mem_ready = 1'b0;

        //    name      rd  wr  ds      f3      addr        wd            rdat          dly  e_addr      e_be     chk  e_wdata       we   e_data        err  st rq
        do_op("lw",     1,  0,  3'b010, 3'b000, 32'h100,    32'h0,        32'hDEADBEEF, 0,   32'h100,    4'b1111, 1,   32'h0,        0,   32'hDEADBEEF, 0,   2, 1);
        do_op("lb",     1,  0,  3'b000, 3'b000, 32'h103,    32'h0,        32'h80112233, 0,   32'h100,    4'b0000, 0,   32'h0,        0,   32'hFFFFFF80, 0,   2, 1);
        do_op("lbu",    1,  0,  3'b100, 3'b000, 32'h103,    32'h0,        32'h80112233, 0,   32'h100,    4'b0000, 0,   32'h0,        0,   32'h00000080, 0,   2, 1);
        do_op("lh",     1,  0,  3'b001, 3'b000, 32'h102,    32'h0,        32'h80112233, 0,   32'h100,    4'b0000, 0,   32'h0,        0,   32'hFFFF8011, 0,   2, 1);
        do_op("lhu",    1,  0,  3'b101, 3'b000, 32'h102,    32'h0,        32'h80112233, 0,   32'h100,    4'b0000, 0,   32'h0,        0,   32'h00008011, 0,   2, 1);
        do_op("lb0",    1,  0,  3'b000, 3'b000, 32'h100,    32'h0,        32'h80112233, 0,   32'h100,    4'b0000, 0,   32'h0,        0,   32'h00000033, 0,   2, 1);
        do_op("sb",     0,  1,  3'b000, 3'b000, 32'h101,    32'h000000A5, 32'h0,        0,   32'h100,    4'b0010, 1,   32'hA5A5A5A5, 1,   32'h0,        0,   2, 1);
        do_op("sh",     0,  1,  3'b000, 3'b001, 32'h102,    32'h00001234, 32'h0,        0,   32'h100,    4'b1100, 1,   32'h12341234, 1,   32'h0,        0,   2, 1);
        do_op("sw",     0,  1,  3'b000, 3'b010, 32'h204,    32'hCAFEF00D, 32'h0,        0,   32'h204,    4'b1111, 1,   32'hCAFEF00D, 1,   32'h0,        0,   2, 1);
        do_op("lwwait", 1,  0,  3'b010, 3'b000, 32'h108,    32'h0,        32'h0BADF00D, 3,   32'h108,    4'b1111, 1,   32'h0,        0,   32'h0BADF00D, 0,   5, 4);
        do_op("lwmis",  1,  0,  3'b010, 3'b000, 32'h102,    32'h0,        32'h12345678, 0,   32'h0,      4'b0000, 0,   32'h0,        0,   32'h0,        1,   1, 0);
        do_op("shmis",  0,  1,  3'b000, 3'b001, 32'h101,    32'h00005555, 32'h0,        0,   32'h0,      4'b0000, 0,   32'h0,        0,   32'h0,        1,   1, 0);
        do_op("ldill",  1,  0,  3'b011, 3'b000, 32'h100,    32'h0,        32'h12345678, 0,   32'h0,      4'b0000, 0,   32'h0,        0,   32'h0,        1,   1, 0);
        do_op("still",  0,  1,  3'b000, 3'b011, 32'h100,    32'h11111111, 32'h0,        0,   32'h0,      4'b0000, 0,   32'h0,        0,   32'h0,        1,   1, 0);
        do_op("both",   1,  1,  3'b010, 3'b010, 32'h10C,    32'h11223344, 32'h99999999, 0,   32'h10C,    4'b1111, 1,   32'h11223344, 1,   32'h0,        0,   2, 1);
        do_op("tmo",    1,  0,  3'b010, 3'b000, 32'h110,    32'h0,        32'h55555555, 100, 32'h110,    4'b1111, 1,   32'h0,        0,   32'h0,        1,   5, 4);

        // Reset arriving in the second REQ cycle abandons the access silently.
        @(posedge clk); #1;
        MemRead       = 1'b1;
        MemWrite      = 1'b0;
        DataSrc       = 3'b010;
        ALUResult     = 32'h120;
        bus.mem_rdata = 32'h77777777;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("rstreq.idle_stall", {31'h0, Stall}, 32'h1);
        @(negedge clk);
        check_eq("rstreq.req1", {31'h0, bus.mem_req}, 32'h1);
        @(negedge clk);
        check_eq("rstreq.req2", {31'h0, bus.mem_req}, 32'h1);
        reset   = 1'b1;
        MemRead = 1'b0;
        #1;
        check_eq("rstreq.stall_forced", {31'h0, Stall}, 32'h0);
        @(negedge clk);
        check_eq("rstreq.req_off", {31'h0, bus.mem_req}, 32'h0);
        check_eq("rstreq.stall", {31'h0, Stall}, 32'h0);
        check_eq("rstreq.err", {31'h0, AccessErr}, 32'h0);
        check_eq("rstreq.rdata", ReadData, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rstreq.post_err", {31'h0, AccessErr}, 32'h0);
            check_eq("rstreq.post_stall", {31'h0, Stall}, 32'h0);
            check_eq("rstreq.post_req", {31'h0, bus.mem_req}, 32'h0);
        end

        check_eq("sb.empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage sitting directly downstream of the main decoder and ALU in the RISC-V core. It takes the decoder's load/store controls (MemWrite, load-select DataSrc, store funct3) with the ALU-computed address and rs2 data. It runs a request/ready handshake to a wait-stated data memory, stalling the core until the access completes. It returns a sign- or zero-extended load result for the register-file write-back mux and flags misaligned, illegal or timed-out accesses.

## Interface
- TIMEOUT, 255: max cycles to wait for mem_ready in REQ; 0 disables the timeout.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load in current instruction (decoder ResultSrc == 01).
- MemWrite  in  1  store in current instruction.
- DataSrc  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- StoreFunct3  in  3  store type: 000 sb, 001 sh, 010 sw.
- ALUResult  in  32  byte address.
- WriteData  in  32  rs2 store data.
- Stall  out  1  hold PC and block register write while 1.
- ReadData  out  32  extended load result; valid only in DONE.
- AccessErr  out  1  one-cycle pulse in DONE for error-terminated accesses.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_ready  in  1  memory accepts/completes request this cycle.
- mem_rdata  in  32  read word; valid when mem_req & mem_ready & !mem_we.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: if MemRead|MemWrite, register addr, data, type and direction. MemWrite wins if both are set; treat as store. Check alignment and type:
  - lw/sw: addr[1:0] must be 00.
  - lh/lhu/sh: addr[0] must be 0.
  - DataSrc 011/110/111 (load) or StoreFunct3 ≥ 011 (store) is illegal.
  - Error → DONE with err flag set and no memory request. Otherwise → REQ and clear the timeout counter.
- REQ: mem_req=1. mem_we, mem_addr, mem_be and mem_wdata come from registered values and are held stable until handshake.
  - Handshake occurs on the edge where mem_req & mem_ready. Loads capture mem_rdata; go to DONE.
  - Each non-ready cycle increments an 8-bit (or wider, to hold TIMEOUT) counter. When it reaches TIMEOUT (≠0), go to DONE with err set, drop mem_req and perform no write-back.
- DONE: one cycle; → IDLE unconditionally. The instruction retires at the end of DONE, so IDLE always sees the next instruction.
- Store lanes:
  - sb: be = 4'b0001<<addr[1:0]; wdata = byte replicated ×4.
  - sh: be = 4'b0011<<addr[1:0]; wdata = halfword replicated ×2.
  - sw: be = 1111; wdata unchanged.
- Load extract: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- ReadData = 0 whenever state ≠ DONE or err is set.
- Stall = !reset & ((state==IDLE & (MemRead|MemWrite)) | state==REQ). Combinational, so the first stall cycle is the decode cycle itself.
- AccessErr = (state==DONE) & err.

## Timing
- Reset values (after reset edge): state IDLE, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, ReadData 0, AccessErr 0, counter 0, err 0. Stall is forced 0 while reset is high.
- Latency with mem_ready tied high: 3 cycles per memory instruction (IDLE-stall, REQ, DONE). Each ready=0 cycle in REQ adds 1.
- Error path (misaligned/illegal): 2 cycles (IDLE-stall, DONE); mem_req never asserts.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then DONE.
- mem_ready while mem_req=0 is ignored.
- Reset in REQ: the next edge returns to IDLE and mem_req=0. No write-back and no AccessErr pulse.
- Non-memory instructions: Stall=0; state stays IDLE.

## Test plan
- lw with ALUResult=0x100, mem_ready=1, mem_rdata=0xDEADBEEF → mem_req high 1 cycle, mem_addr=0x100, be=1111, DONE ReadData=0xDEADBEEF, Stall high 2 cycles.
- lb/lbu at 0x103, rdata=0x80112233 → lb ReadData=0xFFFFFF80, lbu 0x00000080. lh at 0x102 → 0xFFFF8011.
- sb at 0x101, WriteData=0x000000A5 → mem_we=1, be=0010, wdata=0xA5A5A5A5, addr=0x100. sh at 0x102, WriteData=0x1234 → be=1100, wdata=0x12341234.
- mem_ready held low 3 cycles then high on lw → req and addr stable all 4 REQ cycles, Stall 5 cycles total, data captured on the 4th REQ cycle.
- lw at 0x102; sh at 0x101; DataSrc=011 → no mem_req, AccessErr pulses 1 cycle, ReadData=0, Stall 1 cycle.
- TIMEOUT=4, mem_ready=0 forever → mem_req 4 cycles then AccessErr. Separately, reset asserted in the 2nd REQ cycle → IDLE next edge, mem_req=0, Stall=0, no AccessErr.
